// File: rtl/multiplier_pkg.sv
// Shared constants and select codes for the nibble-decomposed multiplier.
package multiplier_pkg;

  localparam int unsigned W = 8;

  typedef enum logic [1:0] {
    ROM_LL = 2'd0,
    ROM_HL = 2'd1,
    ROM_LH = 2'd2,
    ROM_HH = 2'd3
  } sel_rom_e;

  typedef enum logic [1:0] {
    SOMA_AB   = 2'd0,
    SOMA_DEAB = 2'd1,
    SOMA_PASS = 2'd2,
    SOMA_ZERO = 2'd3
  } sel_soma_e;

endpackage

// File: rtl/rom_mult4x4.sv
// Combinational nibble-product table: address {a, b}, data a*b.
module rom_mult4x4 #(
  parameter int unsigned NibW = 4
) (
  input  logic [2*NibW-1:0] addr_i,
  output logic [2*NibW-1:0] data_o
);

  logic [NibW-1:0] nib_a;
  logic [NibW-1:0] nib_b;

  always_comb begin
    nib_a  = addr_i[2*NibW-1:NibW];
    nib_b  = addr_i[NibW-1:0];
    data_o = {{NibW{1'b0}}, nib_a} * {{NibW{1'b0}}, nib_b};
  end

endmodule

// File: rtl/fd_multiplier8bits.sv
// Multiplier datapath: ROM partial products combined by one shared adder,
// sequenced entirely by the external control unit.
module fd_multiplier8bits #(
  parameter int unsigned W = multiplier_pkg::W
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  input  logic           LD_XY,
  input  logic           LD_DE0,
  input  logic           LD_A,
  input  logic           LD_B,
  input  logic           LD_DE1,
  input  logic           LD_AB,
  input  logic           LD_DE_ABshift,
  input  logic           LD_RES,
  input  logic [1:0]     SELROM,
  input  logic [1:0]     SELSOMA,
  input  logic           DONE,
  output logic [2*W-1:0] P,
  output logic           VALID
);
  import multiplier_pkg::*;

  localparam int unsigned H = W / 2;

  logic [W-1:0]   xr_q, yr_q;
  logic [W-1:0]   d0_q, a_q, b_q, d1_q;
  logic [W:0]     ab_q;
  logic [2*W-1:0] de_q, res_q;
  logic           valid_q, valid_d;

  logic [H-1:0]   nib_a, nib_b;
  logic [W-1:0]   rom_data;
  logic [2*W-1:0] sum;

  always_comb begin
    nib_a = xr_q[H-1:0];
    nib_b = yr_q[H-1:0];
    unique case (SELROM)
      ROM_LL: begin nib_a = xr_q[H-1:0]; nib_b = yr_q[H-1:0]; end
      ROM_HL: begin nib_a = xr_q[W-1:H]; nib_b = yr_q[H-1:0]; end
      ROM_LH: begin nib_a = xr_q[H-1:0]; nib_b = yr_q[W-1:H]; end
      ROM_HH: begin nib_a = xr_q[W-1:H]; nib_b = yr_q[W-1:H]; end
      default: ;
    endcase
  end

  rom_mult4x4 #(
    .NibW(H)
  ) u_rom (
    .addr_i({nib_a, nib_b}),
    .data_o(rom_data)
  );

  // Sum is kept at 2W bits: consistent operands never exceed (2^W-1)^2.
  always_comb begin
    sum = '0;
    unique case (SELSOMA)
      SOMA_AB:   sum = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
      SOMA_DEAB: sum = {d1_q, d0_q} + ({{(W-1){1'b0}}, ab_q} << H);
      SOMA_PASS: sum = de_q;
      SOMA_ZERO: sum = '0;
      default:   sum = '0;
    endcase
  end

  // A new operand load invalidates the result even if RES loads the same edge.
  always_comb begin
    valid_d = valid_q;
    if (LD_XY) begin
      valid_d = 1'b0;
    end else if (LD_RES && DONE) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      xr_q    <= '0;
      yr_q    <= '0;
      d0_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d1_q    <= '0;
      ab_q    <= '0;
      de_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (LD_XY) begin
        xr_q <= X;
        yr_q <= Y;
      end
      if (LD_DE0)        d0_q  <= rom_data;
      if (LD_A)          a_q   <= rom_data;
      if (LD_B)          b_q   <= rom_data;
      if (LD_DE1)        d1_q  <= rom_data;
      if (LD_AB)         ab_q  <= sum[W:0];
      if (LD_DE_ABshift) de_q  <= sum;
      if (LD_RES)        res_q <= sum;
      valid_q <= valid_d;
    end
  end

  assign P     = res_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_fd_multiplier8bits.sv
// Directed bench for the multiplier datapath, driving the nominal UC sequence.
module tb_fd_multiplier8bits;

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  X, Y;
  logic        LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES;
  logic [1:0]  SELROM, SELSOMA;
  logic        DONE;
  logic [15:0] P;
  logic        VALID;

  int n_tests = 0;
  int n_fail  = 0;

  fd_multiplier8bits #(
    .W(8)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .X            (X),
    .Y            (Y),
    .LD_XY        (LD_XY),
    .LD_DE0       (LD_DE0),
    .LD_A         (LD_A),
    .LD_B         (LD_B),
    .LD_DE1       (LD_DE1),
    .LD_AB        (LD_AB),
    .LD_DE_ABshift(LD_DE_ABshift),
    .LD_RES       (LD_RES),
    .SELROM       (SELROM),
    .SELSOMA      (SELSOMA),
    .DONE         (DONE),
    .P            (P),
    .VALID        (VALID)
  );

  always #5 clk = ~clk;

  task automatic clear_ctl();
    LD_XY = 0; LD_DE0 = 0; LD_A = 0; LD_B = 0; LD_DE1 = 0;
    LD_AB = 0; LD_DE_ABshift = 0; LD_RES = 0;
    SELROM = 0; SELSOMA = 0; DONE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  // Sets up the controls of nominal step s (1..8) without clocking.
  task automatic set_step(input int s, input logic done_v);
    clear_ctl();
    case (s)
      1: LD_XY = 1;
      2: begin SELROM = 2'd0; LD_DE0 = 1; end
      3: begin SELROM = 2'd1; LD_A = 1; end
      4: begin SELROM = 2'd2; LD_B = 1; end
      5: begin SELROM = 2'd3; LD_DE1 = 1; end
      6: begin SELSOMA = 2'd0; LD_AB = 1; end
      7: begin SELSOMA = 2'd1; LD_DE_ABshift = 1; end
      8: begin SELSOMA = 2'd2; LD_RES = 1; DONE = done_v; end
      default: ;
    endcase
  endtask

  task automatic run_steps(input int first, input int last, input logic done_v);
    for (int s = first; s <= last; s++) begin
      set_step(s, done_v);
      tick();
    end
  endtask

  task automatic run_seq(input logic [7:0] xv, input logic [7:0] yv);
    X = xv;
    Y = yv;
    run_steps(1, 8, 1'b1);
  endtask

  task automatic test_reset();
    RESET = 1;
    tick();
    RESET = 0;
    n_tests++;
    if (P !== 16'h0000) begin
      n_fail++; $display("FAIL reset_p: got %h want 0000", P);
    end
    n_tests++;
    if (VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", VALID);
    end
    n_tests++;
    if (dut.de_q !== 16'd0 || dut.ab_q !== 9'd0) begin
      n_fail++; $display("FAIL reset_regs: de=%0d ab=%0d want 0 0", dut.de_q, dut.ab_q);
    end
  endtask

  task automatic test_nominal();
    run_seq(8'h12, 8'h34);
    n_tests++;
    if (dut.d0_q !== 8'd8 || dut.a_q !== 8'd4 || dut.b_q !== 8'd6 || dut.d1_q !== 8'd3) begin
      n_fail++;
      $display("FAIL nom_partials: got %0d %0d %0d %0d want 8 4 6 3",
               dut.d0_q, dut.a_q, dut.b_q, dut.d1_q);
    end
    n_tests++;
    if (dut.ab_q !== 9'd10) begin
      n_fail++; $display("FAIL nom_ab: got %0d want 10", dut.ab_q);
    end
    n_tests++;
    if (dut.de_q !== 16'd936) begin
      n_fail++; $display("FAIL nom_de: got %0d want 936", dut.de_q);
    end
    n_tests++;
    if (P !== 16'h03A8 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL nom_p: got %h/%b want 03a8/1", P, VALID);
    end
  endtask

  task automatic test_mixed();
    run_seq(8'h3C, 8'hA5);
    n_tests++;
    if (dut.d0_q !== 8'd60 || dut.a_q !== 8'd15 || dut.b_q !== 8'd120 || dut.d1_q !== 8'd30) begin
      n_fail++;
      $display("FAIL mix_partials: got %0d %0d %0d %0d want 60 15 120 30",
               dut.d0_q, dut.a_q, dut.b_q, dut.d1_q);
    end
    n_tests++;
    if (dut.ab_q !== 9'd135) begin
      n_fail++; $display("FAIL mix_ab: got %0d want 135", dut.ab_q);
    end
    n_tests++;
    if (P !== 16'h26AC) begin
      n_fail++; $display("FAIL mix_p: got %h want 26ac", P);
    end
  endtask

  task automatic test_max();
    run_seq(8'hFF, 8'hFF);
    n_tests++;
    if (dut.ab_q !== 9'd450) begin
      n_fail++; $display("FAIL max_ab: got %0d want 450", dut.ab_q);
    end
    n_tests++;
    if (P !== 16'hFE01 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL max_p: got %h/%b want fe01/1", P, VALID);
    end
  endtask

  task automatic test_zero_then_reload();
    run_seq(8'h00, 8'hB7);
    n_tests++;
    if (P !== 16'h0000 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL zero_p: got %h/%b want 0000/1", P, VALID);
    end
    X = 8'h02;
    Y = 8'h03;
    run_steps(1, 1, 1'b1);
    n_tests++;
    if (VALID !== 1'b0 || P !== 16'h0000) begin
      n_fail++; $display("FAIL reload_drop: got %h/%b want 0000/0", P, VALID);
    end
    run_steps(2, 8, 1'b1);
    n_tests++;
    if (P !== 16'h0006 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL reload_p: got %h/%b want 0006/1", P, VALID);
    end
  endtask

  task automatic test_reset_midrun();
    X = 8'h3C;
    Y = 8'hA5;
    run_steps(1, 4, 1'b1);
    set_step(5, 1'b1);
    RESET = 1;
    tick();
    RESET = 0;
    n_tests++;
    if (dut.xr_q !== 8'd0 || dut.yr_q !== 8'd0 || dut.d0_q !== 8'd0 || dut.a_q !== 8'd0 ||
        dut.b_q !== 8'd0 || dut.d1_q !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_regs: xr=%0d yr=%0d d0=%0d a=%0d b=%0d d1=%0d want all 0",
               dut.xr_q, dut.yr_q, dut.d0_q, dut.a_q, dut.b_q, dut.d1_q);
    end
    n_tests++;
    if (P !== 16'h0000 || VALID !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_p: got %h/%b want 0000/0", P, VALID);
    end
    run_seq(8'h3C, 8'hA5);
    n_tests++;
    if (P !== 16'h26AC || VALID !== 1'b1) begin
      n_fail++; $display("FAIL mid_rerun: got %h/%b want 26ac/1", P, VALID);
    end
  endtask

  task automatic test_done_and_collision();
    run_seq(8'h12, 8'h34);
    set_step(8, 1'b0);
    tick();
    n_tests++;
    if (P !== 16'h03A8 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL done_low: got %h/%b want 03a8/1", P, VALID);
    end
    // LD_XY with LD_RES: RES reloads DE (still 936) but VALID must fall
    X = 8'h12;
    Y = 8'h34;
    set_step(8, 1'b1);
    LD_XY = 1;
    tick();
    n_tests++;
    if (VALID !== 1'b0 || P !== 16'h03A8) begin
      n_fail++; $display("FAIL xy_res_collide: got %h/%b want 03a8/0", P, VALID);
    end
    // X/Y move without LD_XY: previously latched 0x12*0x34 must be used
    X = 8'hFF;
    Y = 8'hFF;
    run_steps(2, 8, 1'b1);
    n_tests++;
    if (P !== 16'h03A8 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL xy_hold: got %h/%b want 03a8/1", P, VALID);
    end
  endtask

  initial begin
    RESET = 0;
    X = 0;
    Y = 0;
    clear_ctl();
    test_reset();
    test_nominal();
    test_mixed();
    test_max();
    test_zero_then_reload();
    test_reset_midrun();
    test_done_and_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
